gol_matrix_scan: RTL and testbench
==================================

# gol_matrix_scan

Downstream display stage for the Game-of-Life core. Consumes the 64-bit generation word (`Fgrid`) and drives an 8×8 LED matrix by row multiplexing. Captures a tear-free snapshot of the grid once per display frame and reports the live-cell count of that snapshot. Because the GOL core advances every clock, this block decides which generation is shown.

## Interface
Parameters:
- `CLK_DIV`, default 1000: clock cycles each row is driven. Legal range is ≥ 2.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `grid`  in  64: current generation. Bit `r*8+c` is row r, column c.
- `freeze`  in  1: when high, suppresses snapshot updates.
- `row_sel`  out  8: one-hot row drive, active-high.
- `col_data`  out  8: column drive for the active row, active-high. Equals `frame[row*8 +: 8]`.
- `frame_start`  out  1: single-cycle pulse in the first cycle a new snapshot is displayed.
- `pop_count`  out  7: number of set bits in the displayed snapshot, 0..64.

## Operation
Registered state:
- `state`: LOAD or SCAN.
- `prescaler`: counts 0..CLK_DIV-1.
- `row`: 3 bits.
- `frame`: 64-bit snapshot.
- `pop_count`.
- `frame_start`.

Reset values: state=LOAD, prescaler=0, row=0, frame=0, pop_count=0, frame_start=0.

LOAD state:
- Lasts exactly one cycle. It is the first cycle with `reset` low.
- If `freeze`=0, latch `grid` into `frame` and set `pop_count` to popcount(`grid`).
- Next state is SCAN, with prescaler=0 and row=0.

SCAN state:
- `prescaler` increments each cycle.
- At CLK_DIV-1, `prescaler` wraps to 0 and `row` increments mod 8.
- When the wrap happens with row=7 (frame boundary) and `freeze`=0, latch `grid` and update `pop_count` in the same edge.
- SCAN never exits except through reset.

`frame_start`:
- Registered. It is 1 in the cycle after any latch edge, otherwise 0.
- No pulse occurs when a latch is skipped because `freeze`=1.

Outputs:
- `row_sel` = onehot(row) and `col_data` = frame row, both combinational from registers.
- Both are 0 in LOAD and during reset.

Boundary conditions:
- `freeze` is sampled only at latch edges. Toggling it mid-frame has no visible effect.
- A `grid` change mid-frame is invisible until the next frame boundary.
- Reset asserted mid-scan: on the next edge all state returns to reset values, and outputs go to 0 the following cycle.
- Popcount of all-ones is 64 (7'd64). There is no saturation and no overflow.

## Timing
- Let C0 be the LOAD cycle. In C1: SCAN, row 0, `frame_start`=1, outputs show the snapshot taken at the end of C0.
- Row k is driven during cycles C(1+k·CLK_DIV) .. C((k+1)·CLK_DIV).
- The frame period is 8·CLK_DIV cycles.
- The next latch edge is at the end of C(8·CLK_DIV). The next `frame_start` occurs in C(8·CLK_DIV+1).
- Latency from `grid` sample to display is one cycle.
- `pop_count` always matches the currently displayed `frame`.

## Configuration
`GOL_SCAN_BLANK_EN`:
- Defined: in any SCAN cycle with prescaler=CLK_DIV-1, `row_sel` and `col_data` are forced to 0. This is an anti-ghosting blank before each row change. Counters, latching and `frame_start` are unaffected.
- Undefined: each row is driven for all CLK_DIV cycles.

## Structure
- Package `gol_pkg` holds:
  - `GRID_W`=64.
  - `ROW_W`=8.
  - `scan_state_t` enum {LOAD, SCAN}.
  - A function for the row-slice index.
- Sub-module `gol_popcount` is a purely combinational 64→7 bit count. It is instantiated once, on the `grid` input, and its result is registered at latch edges.
- The top level holds the FSM, counters and snapshot register.

## Test plan
All scenarios use CLK_DIV=4 unless noted.
1. Release reset with grid=64'h0000_0000_0000_00FF → C1: `frame_start`=1, `row_sel`=8'h01, `col_data`=8'hFF, `pop_count`=8. C5: `row_sel`=8'h02, `col_data`=8'h00.
2. Change grid to 64'h8000_0000_0000_0000 at C20 → C29–C32: `row_sel`=8'h80, `col_data`=8'h00 (old frame). C33: `frame_start`=1, `row_sel`=8'h01, `pop_count`=1. C29+32: `col_data`=8'h80.
3. Hold `freeze`=1 across the C32 boundary with a changed grid → no `frame_start`, display and `pop_count` unchanged. Release `freeze` → the next boundary latches.
4. Assert reset while row=5 → next cycle `row_sel`=0, `col_data`=0, `pop_count`=0, `frame_start`=0. Deassert → LOAD, then restart from row 0.
5. grid=all ones → `pop_count`=7'd64 and `col_data`=8'hFF on every row.
6. Check `GOL_SCAN_BLANK_EN` in both builds → defined: `row_sel`=0 in every prescaler=3 cycle. Undefined: the row stays driven for all 4 cycles. Counters are identical in both builds.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life display path: grid geometry,
// scan FSM state type and the row-slice index helper.
package gol_pkg;

  localparam int GRID_W = 64;
  localparam int ROW_W  = 8;

  typedef enum logic {
    LOAD = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // Bit index of column 0 of the given row inside the 64-bit grid word.
  function automatic logic [5:0] row_base(input logic [2:0] row);
    return {row, 3'b000};
  endfunction

endpackage

// File: rtl/gol_popcount.sv
// Purely combinational 64-to-7 bit population count of a grid word.
module gol_popcount
  import gol_pkg::*;
(
  input  logic [GRID_W-1:0] i_vec,
  output logic [6:0]        o_count
);

  // Sum every cell bit; 7 bits hold the full 0..64 range without overflow.
  always_comb begin
    o_count = 7'd0;
    for (int i = 0; i < GRID_W; i++) begin
      o_count = o_count + {6'd0, i_vec[i]};
    end
  end

endmodule

// File: rtl/gol_matrix_scan.sv
// Row-multiplexed 8x8 LED driver for the Game-of-Life core. Takes a tear-free
// snapshot of the grid once per display frame and reports its live-cell count.
// Optional build macro GOL_SCAN_BLANK_EN blanks the drive in the last cycle of
// every row slot (anti-ghosting); counters and latching are unaffected.
module gol_matrix_scan
  import gol_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid,
  input  logic              freeze,
  output logic [ROW_W-1:0]  row_sel,
  output logic [ROW_W-1:0]  col_data,
  output logic              frame_start,
  output logic [6:0]        pop_count
);

  localparam int             PS_W    = $clog2(CLK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);

  scan_state_t       r_state;
  logic [PS_W-1:0]   r_prescaler;
  logic [2:0]        r_row;
  logic [GRID_W-1:0] r_frame;
  logic [6:0]        r_pop_count;
  logic              r_frame_start;

  logic [6:0]        w_grid_pop;
  logic              w_blank;

  gol_popcount u_popcount (
    .i_vec   (grid),
    .o_count (w_grid_pop)
  );

`ifdef GOL_SCAN_BLANK_EN
  assign w_blank = (r_state == SCAN) && (r_prescaler == PS_LAST);
`else
  assign w_blank = 1'b0;
`endif

  // Scan FSM: one LOAD cycle after reset, then endless SCAN with a snapshot
  // latch at every frame boundary unless freeze holds the current picture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= LOAD;
      r_prescaler   <= '0;
      r_row         <= 3'd0;
      r_frame       <= '0;
      r_pop_count   <= 7'd0;
      r_frame_start <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_state     <= SCAN;
          r_prescaler <= '0;
          r_row       <= 3'd0;
          if (!freeze) begin
            r_frame       <= grid;
            r_pop_count   <= w_grid_pop;
            r_frame_start <= 1'b1;
          end else begin
            r_frame_start <= 1'b0;
          end
        end
        SCAN: begin
          if (r_prescaler == PS_LAST) begin
            r_prescaler <= '0;
            r_row       <= r_row + 3'd1;
            if ((r_row == 3'd7) && !freeze) begin
              r_frame       <= grid;
              r_pop_count   <= w_grid_pop;
              r_frame_start <= 1'b1;
            end else begin
              r_frame_start <= 1'b0;
            end
          end else begin
            r_prescaler   <= r_prescaler + PS_W'(1);
            r_frame_start <= 1'b0;
          end
        end
        default: begin
          r_state       <= LOAD;
          r_prescaler   <= '0;
          r_row         <= 3'd0;
          r_frame_start <= 1'b0;
        end
      endcase
    end
  end

  // Matrix drive decoded from the scan registers; dark in LOAD and while blanking.
  always_comb begin
    row_sel  = 8'h00;
    col_data = 8'h00;
    if ((r_state == SCAN) && !w_blank) begin
      row_sel  = 8'h01 << r_row;
      col_data = r_frame[row_base(r_row) +: ROW_W];
    end else begin
      row_sel  = 8'h00;
      col_data = 8'h00;
    end
  end

  assign frame_start = r_frame_start;
  assign pop_count   = r_pop_count;

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Self-checking bench for gol_matrix_scan (CLK_DIV=4). A cycle-indexed
// reference model derives the expected display purely from the frame timing
// arithmetic; directed checks follow the scenario list with literal values.
module tb_gol_matrix_scan;

  localparam int CD = 4;
  localparam int FRAME = 8 * CD;

  logic        clk;
  logic        reset;
  logic [63:0] grid;
  logic        freeze;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;
  logic [6:0]  pop_count;

  int checks;
  int errors;

  // Reference model: m_n is the cycle index counted from the LOAD cycle (C0).
  int          m_n;
  logic [63:0] m_frame;
  int          m_pop;
  logic        m_fs;

  gol_matrix_scan #(.CLK_DIV(CD)) dut (
    .clk         (clk),
    .reset       (reset),
    .grid        (grid),
    .freeze      (freeze),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .pop_count   (pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int count_ones(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at C%0d: observed=%h expected=%h", tag, m_n, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge.
  task automatic tick();
    if (reset) begin
      m_n = 0; m_frame = 64'd0; m_pop = 0; m_fs = 1'b0;
    end else begin
      if ((m_n % FRAME == 0) && !freeze) begin
        m_frame = grid; m_pop = count_ones(grid); m_fs = 1'b1;
      end else begin
        m_fs = 1'b0;
      end
      m_n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic [7:0] e_rs, e_cd;
    int r, ps;
    e_rs = 8'h00; e_cd = 8'h00;
    if (m_n > 0) begin
      r  = ((m_n - 1) / CD) % 8;
      ps = (m_n - 1) % CD;
      e_rs = 8'h01 << r;
      e_cd = m_frame[r*8 +: 8];
`ifdef GOL_SCAN_BLANK_EN
      if (ps == CD - 1) begin e_rs = 8'h00; e_cd = 8'h00; end
`endif
    end
    check("model_row_sel", {56'd0, row_sel}, {56'd0, e_rs});
    check("model_col_data", {56'd0, col_data}, {56'd0, e_cd});
    check("model_frame_start", {63'd0, frame_start}, {63'd0, m_fs});
    check("model_pop_count", {57'd0, pop_count}, 64'(m_pop));
  endtask

  task automatic tick_check();
    tick();
    check_model();
  endtask

  task automatic run_to(input int n);
    while (m_n < n) tick_check();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_n = 0; m_frame = 64'd0; m_pop = 0; m_fs = 1'b0;
    reset = 1'b1; grid = 64'h0000_0000_0000_00FF; freeze = 1'b0;

    // Reset state
    tick(); tick();
    check("reset_row_sel", {56'd0, row_sel}, 64'd0);
    check("reset_col_data", {56'd0, col_data}, 64'd0);
    check("reset_pop", {57'd0, pop_count}, 64'd0);
    check("reset_fs", {63'd0, frame_start}, 64'd0);

    // Scenario 1: release reset, C0 is LOAD
    reset = 1'b0;
    check_model();
    tick_check();
    check("s1_c1_fs", {63'd0, frame_start}, 64'd1);
    check("s1_c1_row_sel", {56'd0, row_sel}, 64'h01);
    check("s1_c1_col", {56'd0, col_data}, 64'hFF);
    check("s1_c1_pop", {57'd0, pop_count}, 64'd8);
    run_to(4);
`ifdef GOL_SCAN_BLANK_EN
    check("s6_blank_c4", {56'd0, row_sel}, 64'h00);
`else
    check("s6_noblank_c4", {56'd0, row_sel}, 64'h01);
`endif
    run_to(5);
    check("s1_c5_row_sel", {56'd0, row_sel}, 64'h02);
    check("s1_c5_col", {56'd0, col_data}, 64'h00);

    // Scenario 2: grid change mid-frame only shows after the boundary
    run_to(20);
    grid = 64'h8000_0000_0000_0000;
    run_to(29);
    check("s2_c29_row_sel", {56'd0, row_sel}, 64'h80);
    check("s2_c29_col_old", {56'd0, col_data}, 64'h00);
    run_to(31);
    check("s2_c31_col_old", {56'd0, col_data}, 64'h00);
    run_to(33);
    check("s2_c33_fs", {63'd0, frame_start}, 64'd1);
    check("s2_c33_row_sel", {56'd0, row_sel}, 64'h01);
    check("s2_c33_pop", {57'd0, pop_count}, 64'd1);
    run_to(61);
    check("s2_c61_col", {56'd0, col_data}, 64'h80);

    // Scenario 3: freeze across a boundary, toggled mid-frame, then released
    freeze = 1'b1;
    grid = {$urandom(), $urandom()};
    run_to(65);
    check("s3_frozen_fs", {63'd0, frame_start}, 64'd0);
    check("s3_frozen_pop", {57'd0, pop_count}, 64'd1);
    run_to(70); freeze = 1'b0;
    run_to(80); freeze = 1'b1;
    run_to(97);
    check("s3_still_frozen_pop", {57'd0, pop_count}, 64'd1);
    freeze = 1'b0;
    grid = {$urandom(), $urandom()} | 64'h1;
    run_to(129);
    check("s3_release_fs", {63'd0, frame_start}, 64'd1);
    check("s3_release_pop", {57'd0, pop_count}, 64'(count_ones(grid)));

    // Scenario 4: reset mid-scan on row 5
    run_to(129 + 5 * CD + 1);
    reset = 1'b1;
    tick_check();
    check("s4_row_sel", {56'd0, row_sel}, 64'd0);
    check("s4_col", {56'd0, col_data}, 64'd0);
    check("s4_pop", {57'd0, pop_count}, 64'd0);
    check("s4_fs", {63'd0, frame_start}, 64'd0);
    reset = 1'b0;
    grid = 64'hFFFF_FFFF_FFFF_FFFF;
    check_model();
    tick_check();
    check("s4_restart_row_sel", {56'd0, row_sel}, 64'h01);
    check("s4_restart_fs", {63'd0, frame_start}, 64'd1);

    // Scenario 5: all ones -> 64 with every row fully lit
    check("s5_pop64", {57'd0, pop_count}, 64'd64);
    for (int r = 0; r < 8; r++) begin
      run_to(1 + r * CD);
      check("s5_col_ff", {56'd0, col_data}, 64'hFF);
    end

    // Randomized phase: grid and freeze change every cycle
    for (int i = 0; i < 4 * FRAME; i++) begin
      grid   = {$urandom(), $urandom()};
      freeze = ($urandom_range(0, 3) == 0);
      tick_check();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
